// File: rtl/ieee1355_pkg.sv
// rtl/ieee1355_pkg.sv - IEEE 1355 DS-link character codes, lengths and parity helper
package ieee1355_pkg;

  localparam logic [1:0] CTRL_FCC   = 2'b00;
  localparam logic [1:0] CTRL_EOP_1 = 2'b01;
  localparam logic [1:0] CTRL_EOP_2 = 2'b10;
  localparam logic [1:0] CTRL_ESC   = 2'b11;

  localparam int DATA_CHAR_LEN = 10;
  localparam int CTRL_CHAR_LEN = 4;
  localparam int NULL_CHAR_LEN = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT
  } tx_state_t;

  // ones_par is the XOR of the previous character's payload bits and the new flag.
  function automatic logic parity_bit(input logic odd, input logic ones_par);
    return ones_par ^ odd;
  endfunction

endpackage

// File: rtl/ds_encoder.sv
// rtl/ds_encoder.sv - DS output stage: data register plus strobe that toggles when data repeats
module ds_encoder (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic load,
  input  logic bit_in,
  output logic d_out,
  output logic s_out
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d_out <= 1'b0;
      s_out <= 1'b0;
    end else if (clear) begin
      d_out <= 1'b0;
      s_out <= 1'b0;
    end else if (load) begin
      d_out <= bit_in;
      if (bit_in == d_out) s_out <= ~s_out;
    end
  end

endmodule

// File: rtl/ds_link_tx.sv
// rtl/ds_link_tx.sv - DS-link character transmitter: framing, parity, NULL fill and bit timing
module ds_link_tx
  import ieee1355_pkg::*;
#(
  parameter int G_LINK_PARITY_IS_ODD = 1,
  parameter int G_CLK_DIV            = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       tx_is_ctrl,
  input  logic [7:0] tx_data,
  input  logic       inject_parity_err,
  output logic       d_out,
  output logic       s_out
);

  localparam logic [7:0] TICK_MAX = 8'(G_CLK_DIV - 1);
  localparam logic       ODD      = (G_LINK_PARITY_IS_ODD != 0);

  tx_state_t  state;
  logic [9:0] shreg;
  logic [3:0] bits_left;
  logic [7:0] tick;
  logic       hist_par;
  logic       ready_q;

  logic [9:0] frame;
  logic [3:0] frame_len;
  logic       frame_par;
  logic       p_first;
  logic       p_fcc;

  // Character offered at the boundary; NULL (ESC+FCC) fills the gap when nothing is valid.
  always_comb begin
    frame     = '0;
    frame_len = 4'(NULL_CHAR_LEN);
    frame_par = 1'b0;
    p_first   = 1'b0;
    p_fcc     = 1'b0;
    if (tx_valid) begin
      if (tx_is_ctrl) begin
        p_first   = parity_bit(ODD, hist_par ^ 1'b1) ^ inject_parity_err;
        frame     = {6'b0, tx_data[1:0], 1'b1, p_first};
        frame_len = 4'(CTRL_CHAR_LEN);
        frame_par = ^tx_data[1:0];
      end else begin
        p_first   = parity_bit(ODD, hist_par) ^ inject_parity_err;
        frame     = {tx_data, 1'b0, p_first};
        frame_len = 4'(DATA_CHAR_LEN);
        frame_par = ^tx_data;
      end
    end else begin
      p_first   = parity_bit(ODD, hist_par ^ 1'b1) ^ inject_parity_err;
      p_fcc     = parity_bit(ODD, (^CTRL_ESC) ^ 1'b1) ^ inject_parity_err;
      frame     = {2'b00, CTRL_FCC, 1'b1, p_fcc, CTRL_ESC, 1'b1, p_first};
      frame_par = ^CTRL_FCC;
    end
  end

  logic       last_tick;
  logic [3:0] bits_left_n;
  logic [7:0] tick_n;
  logic       next_is_load;

  assign last_tick    = (tick == TICK_MAX);
  assign bits_left_n  = last_tick ? bits_left - 4'd1 : bits_left;
  assign tick_n       = last_tick ? 8'd0 : tick + 8'd1;
  assign next_is_load = (bits_left_n == 4'd0) && (tick_n == TICK_MAX);

  logic enc_clear;
  logic enc_load;
  logic enc_bit;

  assign enc_clear = ~enable;
  assign enc_load  = enable && ((state == ST_LOAD) || ((state == ST_SHIFT) && last_tick));
  assign enc_bit   = (state == ST_LOAD) ? frame[0] : shreg[0];
  assign tx_ready  = ready_q & enable;

  // LOAD is the final clock of the previous character (or one idle clock after enable).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      shreg     <= '0;
      bits_left <= '0;
      tick      <= '0;
      hist_par  <= 1'b0;
      ready_q   <= 1'b0;
    end else if (!enable) begin
      state     <= ST_IDLE;
      shreg     <= '0;
      bits_left <= '0;
      tick      <= '0;
      hist_par  <= 1'b0;
      ready_q   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          state   <= ST_LOAD;
          ready_q <= 1'b1;
        end
        ST_LOAD: begin
          shreg     <= frame >> 1;
          bits_left <= frame_len - 4'd1;
          tick      <= 8'd0;
          hist_par  <= frame_par;
          state     <= ST_SHIFT;
          ready_q   <= 1'b0;
        end
        ST_SHIFT: begin
          tick      <= tick_n;
          bits_left <= bits_left_n;
          if (last_tick) shreg <= shreg >> 1;
          if (next_is_load) begin
            state   <= ST_LOAD;
            ready_q <= 1'b1;
          end
        end
        default: begin
          state   <= ST_IDLE;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

  ds_encoder u_enc (
    .clk    (clk),
    .rst    (rst),
    .clear  (enc_clear),
    .load   (enc_load),
    .bit_in (enc_bit),
    .d_out  (d_out),
    .s_out  (s_out)
  );

endmodule
